// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller over an external dual-port RAM with a 2-entry FWFT output stage; 2-cycle empty latency.
// Writes stall only when the RAM is full or during flush; reads stall on m_ready with registered m_valid/m_data.
module dpram_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [LW-1:0] level,
  output logic [AW-1:0] ram_addr_a,
  output logic          ram_wr_a,
  output logic [DW-1:0] ram_din_a,
  output logic [AW-1:0] ram_addr_b,
  output logic          ram_wr_b,
  output logic [DW-1:0] ram_din_b,
  input  logic [DW-1:0] ram_qout_b
);

  localparam logic [AW:0] RAM_FULL = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          in_flight;
  logic          skid_vld;
  logic [DW-1:0] skid_data;
  logic          accept;
  logic          pop;
  logic          issue;
  logic [1:0]    stage_busy;

  assign s_ready = (ram_cnt < RAM_FULL) && !flush;
  assign accept  = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Slots already claimed in the output stage once this cycle's pop is taken out.
  assign stage_busy = {1'b0, m_valid} + {1'b0, skid_vld} + {1'b0, in_flight} - {1'b0, pop};
  assign issue      = (ram_cnt != '0) && !flush && (stage_busy < 2'd2);

  assign ram_addr_a = wr_ptr;
  assign ram_wr_a   = accept;
  assign ram_din_a  = s_data;
  assign ram_addr_b = rd_ptr;
  assign ram_wr_b   = 1'b0;
  assign ram_din_b  = '0;

  assign level = LW'(ram_cnt) + LW'(in_flight) + LW'(m_valid) + LW'(skid_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      in_flight <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else if (flush) begin
      // Clearing in_flight here drops any RAM word returning next cycle.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      in_flight <= 1'b0;
      m_valid   <= 1'b0;
      skid_vld  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (issue)  rd_ptr <= rd_ptr + 1'b1;
      if (accept && !issue)      ram_cnt <= ram_cnt + 1'b1;
      else if (!accept && issue) ram_cnt <= ram_cnt - 1'b1;
      in_flight <= issue;

      if (pop) begin
        if (skid_vld) begin
          m_data   <= skid_data;
          skid_vld <= in_flight;
          if (in_flight) skid_data <= ram_qout_b;
        end else begin
          m_valid <= in_flight;
          if (in_flight) m_data <= ram_qout_b;
        end
      end else if (in_flight) begin
        if (!m_valid) begin
          m_valid <= 1'b1;
          m_data  <= ram_qout_b;
        end else begin
          skid_vld  <= 1'b1;
          skid_data <= ram_qout_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM, queue reference model and a decoupled pop monitor.
module tb_dpram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH) + 2;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [LW-1:0] level;
  logic [AW-1:0] ram_addr_a;
  logic          ram_wr_a;
  logic [DW-1:0] ram_din_a;
  logic [AW-1:0] ram_addr_b;
  logic          ram_wr_b;
  logic [DW-1:0] ram_din_b;
  logic [DW-1:0] ram_qout_b;

  logic [DW-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  dpram_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ram_addr_a(ram_addr_a), .ram_wr_a(ram_wr_a), .ram_din_a(ram_din_a),
    .ram_addr_b(ram_addr_b), .ram_wr_b(ram_wr_b), .ram_din_b(ram_din_b),
    .ram_qout_b(ram_qout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-before-write RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_wr_a) mem[ram_addr_a] <= ram_din_a;
    ram_qout_b <= mem[ram_addr_b];
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: samples just before each rising edge and checks against the queue model.
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_level", int'(level), 0);
    end else begin
      chk("level_vs_model", int'(level), exp_q.size());
      if (prev_hold) begin
        chk("hold_m_valid", int'(m_valid), 1);
        chk("hold_m_data", int'(m_data), int'(prev_data));
      end
      if (flush) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (m_valid && m_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pop_unexpected: got data %0d with model empty", m_data);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(m_data) !== e) begin
              fails++;
              $display("FAIL pop_data: got %0d expected %0d", m_data, e);
            end
          end
        end
        if (s_valid && s_ready) exp_q.push_back(int'(s_data));
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  task automatic drain(input string name);
    int k;
    @(negedge clk);
    s_valid = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    k = 0;
    #4;
    while ((level != '0 || m_valid) && k < 200) begin
      @(negedge clk);
      #4;
      k++;
    end
    chk(name, int'(level), 0);
  endtask

  initial begin
    int n;
    int k;
    int maxlvl;
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("reset_m_valid", int'(m_valid), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_s_ready", int'(s_ready), 1);
    chk("reset_m_data", int'(m_data), 0);

    // 1: single word latency
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    #4;
    chk("t1_vld_e0", int'(m_valid), 0);
    chk("t1_lvl_e0", int'(level), 1);
    @(negedge clk); #4;
    chk("t1_vld_e1", int'(m_valid), 0);
    chk("t1_lvl_e1", int'(level), 1);
    @(negedge clk); #4;
    chk("t1_vld_e2", int'(m_valid), 1);
    chk("t1_data_e2", int'(m_data), 8'hA5);
    @(negedge clk); #4;
    chk("t1_lvl_after_pop", int'(level), 0);
    chk("t1_vld_after_pop", int'(m_valid), 0);

    // 2: fill to capacity with the sink stalled
    n = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'(n);
      #4;
      if (s_ready) n++;
    end
    chk("t2_accepted", n, DEPTH + 2);
    chk("t2_s_ready", int'(s_ready), 0);
    chk("t2_level", int'(level), DEPTH + 2);
    chk("t2_head", int'(m_data), 0);
    chk("t2_m_valid", int'(m_valid), 1);
    drain("t2_drain");

    // 3: full-rate streaming across pointer wrap
    n = 0; k = 0; maxlvl = 0;
    while (n < 100 && k < 400) begin
      @(negedge clk);
      s_valid = 1'b1;
      m_ready = 1'b1;
      s_data  = 8'(n);
      #4;
      if (s_ready) n++;
      if (int'(level) > maxlvl) maxlvl = int'(level);
      k++;
    end
    chk("t3_accepted", n, 100);
    chk("t3_cycles", k, 100);
    chk("t3_maxlvl_le3", int'(maxlvl <= 3), 1);
    drain("t3_drain");

    // 4: random traffic on both sides
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      s_valid = 1'($urandom % 2);
      m_ready = 1'($urandom % 2);
      s_data  = 8'($urandom);
    end
    drain("t4_drain");

    // 5: flush while reads are in flight
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h50 + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    #4;
    chk("t5_s_ready_in_flush", int'(s_ready), 0);
    @(negedge clk);
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #4;
    chk("t5_m_valid_after", int'(m_valid), 0);
    chk("t5_level_after", int'(level), 0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h3C;
    @(negedge clk);
    s_valid = 1'b0;
    #4;
    chk("t5_vld_e0", int'(m_valid), 0);
    @(negedge clk); #4;
    chk("t5_vld_e1", int'(m_valid), 0);
    @(negedge clk); #4;
    chk("t5_vld_e2", int'(m_valid), 1);
    chk("t5_data_e2", int'(m_data), 8'h3C);
    drain("t5_drain");

    // 6: asynchronous reset with words queued
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h60 + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_m_valid_async", int'(m_valid), 0);
    chk("t6_level_async", int'(level), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("t6_s_ready_release", int'(s_ready), 1);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    #4;
    chk("t6_vld_e0", int'(m_valid), 0);
    @(negedge clk); #4;
    chk("t6_vld_e1", int'(m_valid), 0);
    @(negedge clk); #4;
    chk("t6_vld_e2", int'(m_valid), 1);
    chk("t6_data_e2", int'(m_data), 8'h5A);
    drain("t6_drain");

    @(negedge clk); #4;
    chk("final_model_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
